// File: rtl/covox_pkg.sv
// Shared constants and types for the covox sample-playback path.
package covox_pkg;

    localparam int COVOX_DEPTH_LOG2 = 4;
    localparam int COVOX_DIV_W      = 12;
    localparam int SAMPLE_W         = 8;
    localparam int DEPTH            = 1 << COVOX_DEPTH_LOG2;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/covox_fifo.sv
// Single-clock sample FIFO with flush, registered level/flags and a
// registered read-data output that holds its value between reads.
module covox_fifo
    import covox_pkg::*;
#(
    parameter int DEPTH_LOG2 = COVOX_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  sample_t               wr_data,
    input  logic                  rd_en,
    output sample_t               rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int                    N        = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = N[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    sample_t                 mem_q [N];
    sample_t                 mem_d [N];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    sample_t                 rd_data_q, rd_data_d;
    logic                    empty_q, empty_d;
    logic                    full_q, full_d;
    logic                    wr_ok, rd_ok;

    always_comb begin
        rd_ok     = rd_en && !empty_q && !flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_ok     = wr_en && !flush && (!full_q || rd_ok);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (rd_ok) begin
                rd_data_d = mem_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/covox_player.sv
// Covox playback front end: CPU-fed FIFO drained by a programmable rate timer.
// Optional half-empty irq pulse is built only when COVOX_PLAYER_IRQ_EN is defined.
module covox_player
    import covox_pkg::*;
#(
    parameter int DEPTH_LOG2 = COVOX_DEPTH_LOG2,
    parameter int DIV_W      = COVOX_DIV_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SAMPLE_W-1:0]   din,
    input  logic                  fifo_wr,
    input  logic                  flush,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      rate_div,
    output logic [SAMPLE_W-1:0]   smp_out,
    output logic                  smp_wr,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  underrun,
    output logic                  overflow,
    output logic                  irq
);

    localparam logic [DIV_W-1:0] TMR_ONE = 1;

    logic [DIV_W-1:0] timer_q, timer_d;
    logic             smp_wr_q, smp_wr_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             tick;
    logic             pop;

    // smp_wr is a one-cycle valid with no ready: the sound block must take
    // every sample, and smp_out stays stable until the next strobe.
    always_comb begin
        tick = enable && !flush && (timer_q == '0);
        pop  = tick && !fifo_empty;
        if (flush || !enable || tick) begin
            timer_d = rate_div;
        end else begin
            timer_d = timer_q - TMR_ONE;
        end
        smp_wr_d = pop;
        if (flush) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            underrun_d = underrun_q || (tick && fifo_empty);
            overflow_d = overflow_q || (fifo_wr && fifo_full && !pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            smp_wr_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            smp_wr_q   <= smp_wr_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    covox_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (fifo_wr),
        .wr_data (din),
        .rd_en   (pop),
        .rd_data (smp_out),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

`ifdef COVOX_PLAYER_IRQ_EN
    localparam int                  HALF_P1 = (1 << (DEPTH_LOG2 - 1)) + 1;
    localparam logic [DEPTH_LOG2:0] LVL_HALF_P1 = HALF_P1[DEPTH_LOG2:0];

    logic irq_q, irq_d;

    // A concurrent write keeps the level put, so it must not count as a crossing.
    always_comb begin
        irq_d = pop && !fifo_wr && (fifo_level == LVL_HALF_P1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign smp_wr   = smp_wr_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_covox_player.sv
// Directed bench for covox_player; irq expectations follow COVOX_PLAYER_IRQ_EN.
module tb_covox_player;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        fifo_wr;
    logic        flush;
    logic        enable;
    logic [11:0] rate_div;
    logic [7:0]  smp_out;
    logic        smp_wr;
    logic [4:0]  fifo_level;
    logic        fifo_empty;
    logic        fifo_full;
    logic        underrun;
    logic        overflow;
    logic        irq;

    int n_checks;
    int n_fail;
    int cyc;
    int n0;

    logic [7:0] exp_q[$];
    logic [7:0] ev_dat_q[$];
    int         ev_cyc_q[$];
    int         irq_q[$];

    covox_player dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .fifo_wr    (fifo_wr),
        .flush      (flush),
        .enable     (enable),
        .rate_div   (rate_div),
        .smp_out    (smp_out),
        .smp_wr     (smp_wr),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .underrun   (underrun),
        .overflow   (overflow),
        .irq        (irq)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (smp_wr) begin
            ev_cyc_q.push_back(cyc);
            ev_dat_q.push_back(smp_out);
        end
        if (irq) irq_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cyc_at(input int i);
        return (i < ev_cyc_q.size()) ? ev_cyc_q[i] : -1;
    endfunction

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, ev_dat_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_dat_q.size(); i++)
            check_eq($sformatf("%s_d%0d", tag, i), ev_dat_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic clear_mon();
        ev_cyc_q.delete();
        ev_dat_q.delete();
        irq_q.delete();
        exp_q.delete();
    endtask

    // driver tasks: every step leaves the bench 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        fifo_wr  = 1'b0;
        flush    = 1'b0;
        enable   = 1'b0;
        din      = 8'h00;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        din     = d;
        fifo_wr = 1'b1;
        step();
        fifo_wr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        din      = 8'h00;
        fifo_wr  = 1'b0;
        flush    = 1'b0;
        enable   = 1'b0;
        rate_div = 12'd3;

        // reset values
        @(negedge clk);
        check_eq("rst_smp_out", smp_out, 0);
        check_eq("rst_smp_wr", smp_wr, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_empty", fifo_empty, 1);
        check_eq("rst_full", fifo_full, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_irq", irq, 0);

        // basic playback at period 4
        do_reset();
        rate_div = 12'd3;
        write_byte(8'h11);
        write_byte(8'h22);
        @(negedge clk);
        check_eq("t1_level2", fifo_level, 2);
        step();
        clear_mon();
        n0 = cyc;
        enable = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        repeat (10) step();
        @(negedge clk);
        check_eq("t1_no_underrun_yet", underrun, 0);
        check_eq("t1_level0", fifo_level, 0);
        repeat (3) step();
        @(negedge clk);
        check_eq("t1_underrun", underrun, 1);
        check_eq("t1_empty", fifo_empty, 1);
        check_eq("t1_first_cyc", cyc_at(0) - n0, 4);
        check_eq("t1_spacing", cyc_at(1) - cyc_at(0), 4);
        check_stream("t1");

        // overfill then drain at full rate
        do_reset();
        rate_div = 12'd0;
        for (int i = 0; i < 17; i++) write_byte(i[7:0]);
        @(negedge clk);
        check_eq("t2_level16", fifo_level, 16);
        check_eq("t2_full", fifo_full, 1);
        check_eq("t2_empty", fifo_empty, 0);
        check_eq("t2_overflow", overflow, 1);
        step();
        clear_mon();
        n0 = cyc;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(i[7:0]);
        repeat (20) step();
        @(negedge clk);
        check_eq("t2_last_cyc", cyc_at(15) - n0, 16);
        check_eq("t2_underrun", underrun, 1);
        check_eq("t2_overflow_sticky", overflow, 1);
        check_stream("t2");

        // write and pop together while full
        do_reset();
        rate_div = 12'd0;
        for (int i = 0; i < 16; i++) write_byte(8'h40 + i[7:0]);
        clear_mon();
        enable  = 1'b1;
        din     = 8'hAB;
        fifo_wr = 1'b1;
        step();
        fifo_wr = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        check_eq("t3_level16", fifo_level, 16);
        check_eq("t3_full", fifo_full, 1);
        check_eq("t3_no_overflow", overflow, 0);
        step();
        enable = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + i[7:0]);
        exp_q.push_back(8'hAB);
        repeat (20) step();
        @(negedge clk);
        check_eq("t3_overflow_end", overflow, 0);
        check_stream("t3");

        // write on a tick while empty
        do_reset();
        rate_div = 12'd3;
        repeat (2) step();
        clear_mon();
        n0 = cyc;
        enable = 1'b1;
        repeat (3) step();
        din     = 8'hAA;
        fifo_wr = 1'b1;
        step();
        fifo_wr = 1'b0;
        @(negedge clk);
        check_eq("t4_underrun", underrun, 1);
        check_eq("t4_no_smp_wr", smp_wr, 0);
        check_eq("t4_level1", fifo_level, 1);
        exp_q.push_back(8'hAA);
        repeat (5) step();
        @(negedge clk);
        check_eq("t4_play_cyc", cyc_at(0) - n0, 8);
        check_stream("t4");

        // flush mid-playback with a concurrent write, then async reset
        do_reset();
        rate_div = 12'd0;
        enable   = 1'b1;
        repeat (2) step();
        enable   = 1'b0;
        rate_div = 12'd3;
        for (int i = 0; i < 9; i++) write_byte(8'h91 + i[7:0]);
        @(negedge clk);
        check_eq("t5_level9", fifo_level, 9);
        check_eq("t5_underrun_pre", underrun, 1);
        step();
        clear_mon();
        enable = 1'b1;
        repeat (5) step();
        flush   = 1'b1;
        din     = 8'hEE;
        fifo_wr = 1'b1;
        step();
        flush   = 1'b0;
        fifo_wr = 1'b0;
        @(negedge clk);
        check_eq("t5_flush_level", fifo_level, 0);
        check_eq("t5_flush_empty", fifo_empty, 1);
        check_eq("t5_flush_underrun", underrun, 0);
        check_eq("t5_flush_overflow", overflow, 0);
        check_eq("t5_smp_out_hold", smp_out, 8'h91);
        exp_q.push_back(8'h91);
        repeat (30) step();
        @(negedge clk);
        check_stream("t5");
        check_eq("t5_underrun_again", underrun, 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_arst_smp_out", smp_out, 0);
        check_eq("t5_arst_underrun", underrun, 0);
        check_eq("t5_arst_level", fifo_level, 0);
        check_eq("t5_arst_empty", fifo_empty, 1);
        check_eq("t5_arst_smp_wr", smp_wr, 0);
        step();
        rst_n = 1'b1;

        // half-empty interrupt
        do_reset();
        rate_div = 12'd0;
        clear_mon();
        for (int i = 0; i < 16; i++) write_byte(8'hC0 + i[7:0]);
        enable = 1'b1;
        repeat (20) step();
        enable = 1'b0;
        @(negedge clk);
`ifdef COVOX_PLAYER_IRQ_EN
        check_eq("t6_irq_count", irq_q.size(), 1);
        check_eq("t6_irq_cyc", (irq_q.size() > 0) ? irq_q[0] : -2, cyc_at(7));
`else
        check_eq("t6_irq_count", irq_q.size(), 0);
`endif
        check_eq("t6_pops", ev_dat_q.size(), 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
